// File: rtl/ps2_rx_queue_if.sv
// Bundles the PS/2 pin inputs and the consumer-side queue signals of ps2_rx_queue.
interface ps2_rx_queue_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  ps2_clk;
    logic                  ps2_data;
    logic                  nextdata_n;
    logic                  err_clr;
    logic [7:0]            data;
    logic                  data_ext;
    logic                  data_brk;
    logic                  ready;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  parity_err;
    logic                  frame_err;
    logic [7:0]            key_count;

    modport master (
        output ps2_clk, ps2_data, nextdata_n, err_clr,
        input  data, data_ext, data_brk, ready, level,
        input  overflow, parity_err, frame_err, key_count
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n, err_clr,
        output data, data_ext, data_brk, ready, level,
        output overflow, parity_err, frame_err, key_count
    );
endinterface

// File: rtl/ps2_rx_queue.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered pins, frame FSM
// with timeout recovery, optional E0/F0 prefix folding, and a scan-code queue.
module ps2_rx_queue #(
    parameter int DEPTH_LOG2     = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RAW_MODE       = 0
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_rx_queue_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]          clk_s_q, dat_s_q;
    logic                filt_q;
    logic [FW-1:0]       filt_cnt_q;
    logic                fall;
    logic                din;

    logic [1:0]          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                byte_ok, par_set, frm_set;
    logic                valid_q;
    logic [7:0]          byte_q;

    logic                ext_q, ext_d, brk_q, brk_d;
    logic                push, kc_inc;
    logic [9:0]          ent;
    logic [7:0]          kc_q;

    logic [9:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_q, rd_q;
    logic                full, empty, pop, wr_en, ovf_set;
    logic                ovf_q, perr_q, ferr_q;
    logic [9:0]          head;

    // Two-flop synchronisers for both pins; idle level of the PS/2 bus is high.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s_q <= '1;
            dat_s_q <= '1;
        end else begin
            clk_s_q <= {clk_s_q[0], bus.ps2_clk};
            dat_s_q <= {dat_s_q[0], bus.ps2_data};
        end
    end

    // Filtered clock follows the synced clock only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s_q[1] == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_s_q[1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // Bit strobe fires on the cycle the filtered clock commits to a 1->0 change.
    assign fall = filt_q && !clk_s_q[1] && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign din  = dat_s_q[1];

    // Frame FSM: advances on strobes, falls back to IDLE if a frame stalls too long.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_ok = 1'b0;
        par_set = 1'b0;
        frm_set = 1'b0;
        tcnt_d  = (state_q == S_IDLE) ? '0 : tcnt_q + 1'b1;
        if (fall) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: if (!din) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                end
                S_DATA: begin
                    shift_d = {din, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_PAR;
                end
                S_PAR: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
                default: begin
                    if (!(^{shift_q, par_q})) par_set = 1'b1;
                    else if (!din)            frm_set = 1'b1;
                    else                      byte_ok = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            frm_set = 1'b1;
        end
    end

    // Frame FSM state and the one-cycle valid-byte pulse feeding the decoder.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            valid_q <= byte_ok;
            if (byte_ok) byte_q <= shift_q;
        end
    end

    // Prefix decoder: folds E0/F0 into tag bits unless raw mode queues every byte.
    always_comb begin
        push   = 1'b0;
        kc_inc = 1'b0;
        ent    = {2'b00, byte_q};
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (valid_q) begin
            if (RAW_MODE != 0) begin
                push   = 1'b1;
                kc_inc = (byte_q == 8'hF0);
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push   = 1'b1;
                ent    = {ext_q, brk_q, byte_q};
                kc_inc = brk_q;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                     (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
    assign pop     = !empty && !bus.nextdata_n;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    // Queue storage; a dropped push leaves the contents untouched.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[DEPTH_LOG2-1:0]] <= ent;
    end

    // Pointers, prefix latches, break counter and sticky flags (a set beats err_clr).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            kc_q   <= '0;
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            if (kc_inc) kc_q <= kc_q + 8'd1;
            if (ovf_set) ovf_q <= 1'b1;
            perr_q <= par_set | (perr_q & ~bus.err_clr);
            ferr_q <= frm_set | (ferr_q & ~bus.err_clr);
        end
    end

    assign head           = mem[rd_q[DEPTH_LOG2-1:0]];
    assign bus.data       = head[7:0];
    assign bus.data_brk   = head[8];
    assign bus.data_ext   = head[9];
    assign bus.ready      = !empty;
    assign bus.level      = wr_q - rd_q;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.key_count  = kc_q;
endmodule

// File: tb/tb_ps2_rx_queue.sv
// Scoreboard bench for ps2_rx_queue: a decoding DUT checked by a popping monitor,
// plus a raw-mode DUT exercised with directed frames and a mid-frame reset.
module tb_ps2_rx_queue;
    localparam int HALF = 20;
    localparam int TMO  = 300;

    logic clk = 1'b0;
    logic rstn0, rstn1;
    logic pc0, pd0, nd0, ec0;
    logic pc1, pd1, nd1, ec1;
    logic pop_en;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb[$];
    logic       m_ext, m_brk, m_perr, m_ferr, m_ovf;
    logic [7:0] m_kc;

    always #5 clk = ~clk;

    ps2_rx_queue_if #(.DEPTH_LOG2(3)) bus0 ();
    ps2_rx_queue_if #(.DEPTH_LOG2(3)) bus1 ();

    assign bus0.ps2_clk    = pc0;
    assign bus0.ps2_data   = pd0;
    assign bus0.nextdata_n = nd0;
    assign bus0.err_clr    = ec0;
    assign bus1.ps2_clk    = pc1;
    assign bus1.ps2_data   = pd1;
    assign bus1.nextdata_n = nd1;
    assign bus1.err_clr    = ec1;

    ps2_rx_queue #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .RAW_MODE(0))
        dut0 (.clk(clk), .clrn(rstn0), .bus(bus0));
    ps2_rx_queue #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .RAW_MODE(1))
        dut1 (.clk(clk), .clrn(rstn1), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lines(input int sel, input logic c, input logic d);
        if (sel == 0) begin pc0 = c; pd0 = d; end
        else          begin pc1 = c; pd1 = d; end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Device-side bit timing: data changes while clk is high, host samples on the falling edge.
    task automatic send_bits(input int sel, input logic [10:0] frm, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            set_lines(sel, 1'b1, frm[i]);
            wait_clks(HALF);
            set_lines(sel, 1'b0, frm[i]);
            wait_clks(HALF);
        end
        set_lines(sel, 1'b1, 1'b1);
        wait_clks(2 * HALF);
    endtask

    // Reference model of the decoding receiver, updated as each frame is issued.
    task automatic send0(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        if (bad_par) m_perr = 1'b1;
        else if (bad_stop) m_ferr = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_brk) m_kc = m_kc + 8'd1;
            if (!pop_en && sb.size() == 8) m_ovf = 1'b1;
            else sb.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        send_bits(0, make_frame(b, bad_par, bad_stop), 11);
    endtask

    task automatic chk_flags0(input string tag);
        check({tag, "_parity_err"}, 32'(bus0.parity_err), 32'(m_perr));
        check({tag, "_frame_err"},  32'(bus0.frame_err),  32'(m_ferr));
        check({tag, "_overflow"},   32'(bus0.overflow),   32'(m_ovf));
        check({tag, "_key_count"},  32'(bus0.key_count),  32'(m_kc));
        if (!pop_en) begin
            check({tag, "_level"}, 32'(bus0.level), 32'(sb.size()));
            check({tag, "_ready"}, 32'(bus0.ready), 32'(sb.size() != 0));
        end
    endtask

    task automatic clear_err0();
        @(negedge clk) ec0 = 1'b1;
        @(negedge clk) ec0 = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        wait_clks(1);
    endtask

    task automatic drain0(input string tag);
        int n;
        pop_en = 1'b1;
        n = 0;
        while (!(sb.size() == 0 && !bus0.ready) && n < 4000) begin
            wait_clks(1);
            n++;
        end
        check({tag, "_drained"}, 32'(sb.size() == 0 && !bus0.ready), 32'd1);
        pop_en = 1'b0;
        wait_clks(3);
    endtask

    // Monitor: pops the decoding DUT at random and compares each head against the scoreboard.
    initial begin
        logic [9:0] exp;
        nd0 = 1'b1;
        forever begin
            @(negedge clk);
            if (pop_en && bus0.ready && $urandom_range(0, 3) != 0) begin
                check("queue_has_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("head_entry", 32'({bus0.data_ext, bus0.data_brk, bus0.data}), 32'(exp));
                end
                nd0 = 1'b0;
            end else begin
                nd0 = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rstn0 = 1'b0; rstn1 = 1'b0;
        pc0 = 1'b1; pd0 = 1'b1; ec0 = 1'b0;
        pc1 = 1'b1; pd1 = 1'b1; ec1 = 1'b0; nd1 = 1'b1;
        pop_en = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0; m_kc = '0;
        wait_clks(5);
        rstn0 = 1'b1; rstn1 = 1'b1;
        wait_clks(2);
        chk_flags0("reset");
        check("reset_raw_ready", 32'(bus1.ready), 32'd0);

        // Single plain frame, then a fully prefixed break of an extended key.
        send0(8'h1C, 1'b0, 1'b0);
        chk_flags0("plain");
        check("plain_data", 32'(bus0.data), 32'h1C);
        send0(8'hE0, 1'b0, 1'b0);
        send0(8'hF0, 1'b0, 1'b0);
        send0(8'h75, 1'b0, 1'b0);
        chk_flags0("prefixed");
        drain0("prefixed");

        // Parity error drops the byte and sets a sticky flag that err_clr removes.
        send0(8'h1C, 1'b1, 1'b0);
        chk_flags0("bad_parity");
        clear_err0();
        chk_flags0("parity_cleared");

        // Fill past capacity with no pops; the ninth byte is dropped.
        for (int i = 1; i <= 9; i++) send0(8'(i), 1'b0, 1'b0);
        chk_flags0("overflow");
        drain0("overflow");

        // Stalled frame recovers via timeout, then a normal frame still lands.
        send_bits(0, make_frame(8'h5A, 1'b0, 1'b0), 5);
        m_ferr = 1'b1;
        wait_clks(TMO + 20);
        chk_flags0("timeout");
        send0(8'h29, 1'b0, 1'b0);
        chk_flags0("after_timeout");
        drain0("after_timeout");
        clear_err0();

        // Zero stop bit with good parity is a framing error.
        send0(8'h33, 1'b0, 1'b1);
        chk_flags0("bad_stop");
        clear_err0();

        // Randomised traffic with concurrent popping.
        pop_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            send0(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            chk_flags0("random");
            if ($urandom_range(0, 3) == 0) clear_err0();
        end
        drain0("random");

        // Raw mode: prefixes are queued as ordinary bytes; F0 still counts a break.
        send_bits(1, make_frame(8'hF0, 1'b0, 1'b0), 11);
        send_bits(1, make_frame(8'h1C, 1'b0, 1'b0), 11);
        check("raw_level", 32'(bus1.level), 32'd2);
        check("raw_head0", 32'({bus1.data_ext, bus1.data_brk, bus1.data}), 32'h0F0);
        check("raw_key_count", 32'(bus1.key_count), 32'd1);
        @(negedge clk) nd1 = 1'b0;
        @(negedge clk) nd1 = 1'b1;
        wait_clks(1);
        check("raw_head1", 32'({bus1.data_ext, bus1.data_brk, bus1.data}), 32'h01C);
        check("raw_level_pop", 32'(bus1.level), 32'd1);

        // Reset in the middle of a frame wipes queue, flags and counter.
        send_bits(1, make_frame(8'h55, 1'b0, 1'b0), 4);
        rstn1 = 1'b0;
        wait_clks(2);
        check("raw_rst_level", 32'(bus1.level), 32'd0);
        check("raw_rst_ready", 32'(bus1.ready), 32'd0);
        check("raw_rst_flags", 32'({bus1.overflow, bus1.parity_err, bus1.frame_err}), 32'd0);
        check("raw_rst_key_count", 32'(bus1.key_count), 32'd0);
        rstn1 = 1'b1;
        wait_clks(2);
        send_bits(1, make_frame(8'h3A, 1'b0, 1'b0), 11);
        check("raw_after_rst_level", 32'(bus1.level), 32'd1);
        check("raw_after_rst_data", 32'(bus1.data), 32'h3A);
        check("raw_after_rst_flags", 32'({bus1.parity_err, bus1.frame_err}), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
